// File: rtl/game_state_ctrl_pkg.sv
// Shared game-level types and defaults used by the sequencer and the colour mux.
package game_pkg;

  localparam int DEF_LIVES          = 3;
  localparam int DEF_RESPAWN_FRAMES = 120;
  localparam int DEF_INVULN_FRAMES  = 90;
  localparam int DEF_BLINK_FRAMES   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_DYING  = 3'd2,
    ST_INVULN = 3'd3,
    ST_LOST   = 3'd4,
    ST_WON    = 3'd5
  } game_state_e;

  localparam logic [1:0] SCR_NORMAL = 2'd0;
  localparam logic [1:0] SCR_RED    = 2'd1;
  localparam logic [1:0] SCR_GREEN  = 2'd2;
  localparam logic [1:0] SCR_BLACK  = 2'd3;

  function automatic logic freeze_of(game_state_e s);
    case (s)
      ST_PLAY, ST_INVULN: freeze_of = 1'b0;
      default:            freeze_of = 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] mode_of(game_state_e s);
    case (s)
      ST_PLAY, ST_INVULN: mode_of = SCR_NORMAL;
      ST_DYING, ST_LOST:  mode_of = SCR_RED;
      ST_WON:             mode_of = SCR_GREEN;
      default:            mode_of = SCR_BLACK;
    endcase
  endfunction

  function automatic int timer_width(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/game_state_ctrl_frame_timer.sv
// vsync falling-edge detector plus a loadable, saturating frame down-counter.
module frame_timer #(
  parameter int TW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          tick,
  output logic          done
);

  logic          vsync_prev_r;
  logic [TW-1:0] cnt_r;

  assign tick = vsync_prev_r & ~vsync;
  // done fires on the tick that takes the count to zero, so a load of N spans exactly N ticks
  assign done = en & tick & (cnt_r <= TW'(1));

  // vsync history and saturating count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_prev_r <= 1'b1;
      cnt_r        <= {TW{1'b0}};
    end else begin
      vsync_prev_r <= vsync;
      if (load) begin
        cnt_r <= load_val;
      end else if (en && tick && (cnt_r != {TW{1'b0}})) begin
        cnt_r <= cnt_r - TW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: lives, respawn delay, invulnerability blink and screen mode.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       enemy_hit,
  input  logic       bomb_hit,
  input  logic       all_killed,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic       freeze,
  output logic       round_reset,
  output logic [1:0] screen_mode,
  output logic       bm_visible
);

  localparam int TW = timer_width(RESPAWN_FRAMES, INVULN_FRAMES);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  game_state_e   state_r, state_nx_s;
  logic [2:0]    lives_r, lives_nx_s;
  logic          round_reset_r, round_reset_nx_s;
  logic          freeze_r;
  logic [1:0]    screen_mode_r;
  logic          bm_visible_r, bm_visible_nx_s;
  logic [BW-1:0] blink_r, blink_nx_s;
  logic          tick_s, done_s, load_s, timer_en_s, hit_s;
  logic [TW-1:0] load_val_s;

  assign hit_s      = enemy_hit | bomb_hit;
  assign timer_en_s = (state_r == ST_DYING) || (state_r == ST_INVULN);

  frame_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (timer_en_s),
    .tick     (tick_s),
    .done     (done_s)
  );

  // next-state, lives, timer load and blink decisions
  always_comb begin
    state_nx_s       = state_r;
    lives_nx_s       = lives_r;
    round_reset_nx_s = 1'b0;
    bm_visible_nx_s  = bm_visible_r;
    blink_nx_s       = blink_r;
    load_s           = 1'b0;
    load_val_s       = {TW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        bm_visible_nx_s = 1'b1;
        if (start) begin
          state_nx_s       = ST_PLAY;
          round_reset_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        bm_visible_nx_s = 1'b1;
        if (hit_s) begin
          if (lives_r <= 3'd1) begin
            lives_nx_s = 3'd0;
            state_nx_s = ST_LOST;
          end else begin
            lives_nx_s = lives_r - 3'd1;
            state_nx_s = ST_DYING;
            load_s     = 1'b1;
            load_val_s = TW'(RESPAWN_FRAMES);
          end
        end else if (all_killed) begin
          state_nx_s = ST_WON;
        end else begin
          state_nx_s = ST_PLAY;
        end
      end
      ST_DYING: begin
        if (done_s) begin
          state_nx_s       = ST_INVULN;
          round_reset_nx_s = 1'b1;
          load_s           = 1'b1;
          load_val_s       = TW'(INVULN_FRAMES);
          bm_visible_nx_s  = 1'b1;
          blink_nx_s       = {BW{1'b0}};
        end else begin
          state_nx_s = ST_DYING;
        end
      end
      ST_INVULN: begin
        if (all_killed) begin
          state_nx_s      = ST_WON;
          bm_visible_nx_s = 1'b1;
        end else if (done_s) begin
          state_nx_s      = ST_PLAY;
          bm_visible_nx_s = 1'b1;
        end else if (tick_s) begin
          if (blink_r == BW'(BLINK_FRAMES - 1)) begin
            blink_nx_s      = {BW{1'b0}};
            bm_visible_nx_s = ~bm_visible_r;
          end else begin
            blink_nx_s = blink_r + BW'(1);
          end
        end else begin
          state_nx_s = ST_INVULN;
        end
      end
      ST_LOST, ST_WON: begin
        bm_visible_nx_s = 1'b1;
        if (start) begin
          state_nx_s       = ST_IDLE;
          lives_nx_s       = 3'(LIVES);
          round_reset_nx_s = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // registered state and outputs; freeze/screen mode follow the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      lives_r       <= 3'(LIVES);
      round_reset_r <= 1'b0;
      freeze_r      <= 1'b1;
      screen_mode_r <= SCR_BLACK;
      bm_visible_r  <= 1'b1;
      blink_r       <= {BW{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      lives_r       <= lives_nx_s;
      round_reset_r <= round_reset_nx_s;
      freeze_r      <= freeze_of(state_nx_s);
      screen_mode_r <= mode_of(state_nx_s);
      bm_visible_r  <= bm_visible_nx_s;
      blink_r       <= blink_nx_s;
    end
  end

  assign state       = state_r;
  assign lives       = lives_r;
  assign round_reset = round_reset_r;
  assign freeze      = freeze_r;
  assign screen_mode = screen_mode_r;
  assign bm_visible  = bm_visible_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench: directed game scenario plus random play against a frame-counting model.
module tb_game_state_ctrl;

  localparam int P_LIVES = 3;
  localparam int P_RESP  = 120;
  localparam int P_INV   = 90;
  localparam int P_BLINK = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       enemy_hit = 1'b0;
  logic       bomb_hit = 1'b0;
  logic       all_killed = 1'b0;
  logic [2:0] state;
  logic [2:0] lives;
  logic       freeze;
  logic       round_reset;
  logic [1:0] screen_mode;
  logic       bm_visible;

  int tests = 0;
  int fails = 0;

  game_state_ctrl #(
    .LIVES(P_LIVES), .RESPAWN_FRAMES(P_RESP), .INVULN_FRAMES(P_INV), .BLINK_FRAMES(P_BLINK)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .enemy_hit(enemy_hit), .bomb_hit(bomb_hit), .all_killed(all_killed),
    .state(state), .lives(lives), .freeze(freeze), .round_reset(round_reset),
    .screen_mode(screen_mode), .bm_visible(bm_visible)
  );

  always #5 clk = ~clk;

  // model: st 0 IDLE,1 PLAY,2 DYING,3 INVULN,4 LOST,5 WON; left = frames remaining, elapsed = frames into INVULN
  typedef struct packed {
    int st;
    int lives;
    int left;
    int elapsed;
    bit rr;
    bit prev;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.lives = P_LIVES; r.left = 0; r.elapsed = 0; r.rr = 1'b0; r.prev = 1'b1;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t c, logic vs, logic st_in, logic eh, logic bh, logic ak);
    mdl_t n = c;
    bit tick = c.prev && !vs;
    bit hit = eh || bh;
    n.rr = 1'b0;
    n.prev = vs;
    case (c.st)
      0: if (st_in) begin n.st = 1; n.rr = 1'b1; end
      1: begin
        if (hit) begin
          if (c.lives == 1) begin n.lives = 0; n.st = 4; end
          else begin n.lives = c.lives - 1; n.st = 2; n.left = P_RESP; end
        end else if (ak) n.st = 5;
      end
      2: if (tick) begin
        n.left = c.left - 1;
        if (n.left == 0) begin n.st = 3; n.rr = 1'b1; n.left = P_INV; n.elapsed = 0; end
      end
      3: begin
        if (ak) n.st = 5;
        else if (tick) begin
          n.left = c.left - 1;
          n.elapsed = c.elapsed + 1;
          if (n.left == 0) n.st = 1;
        end
      end
      4, 5: if (st_in) begin n.st = 0; n.lives = P_LIVES; n.rr = 1'b1; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic int exp_freeze(int s);
    return (s == 1 || s == 3) ? 0 : 1;
  endfunction

  function automatic int exp_mode(int s);
    case (s)
      1, 3: return 0;
      2, 4: return 1;
      5: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int exp_vis(mdl_t c);
    if (c.st == 3) return ((c.elapsed / P_BLINK) % 2 == 0) ? 1 : 0;
    return 1;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model tracks the DUT edge for edge
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mdl_reset();
    else m <= step(m, vsync, start, enemy_hit, bomb_hit, all_killed);
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("state", int'(state), m.st);
    check("lives", int'(lives), m.lives);
    check("freeze", int'(freeze), exp_freeze(m.st));
    check("round_reset", int'(round_reset), int'(m.rr));
    check("screen_mode", int'(screen_mode), exp_mode(m.st));
    check("bm_visible", int'(bm_visible), exp_vis(m));
  end

  task automatic pulse(ref logic sig);
    sig = 1'b1;
    @(negedge clk);
    sig = 1'b0;
  endtask

  task automatic frame_fall();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_freeze", int'(freeze), 1);
    check("rst_mode", int'(screen_mode), 3);
    check("rst_vis", int'(bm_visible), 1);
    reset = 1'b1;
    @(negedge clk);

    pulse(start);
    check("start_state", int'(state), 1);
    check("start_rr", int'(round_reset), 1);
    check("start_freeze", int'(freeze), 0);
    @(negedge clk);
    check("rr_one_cycle", int'(round_reset), 0);
    pulse(start);
    check("start_in_play", int'(state), 1);

    pulse(enemy_hit);
    check("hit_lives", int'(lives), 2);
    check("hit_state", int'(state), 2);
    check("hit_mode", int'(screen_mode), 1);
    pulse(start);
    check("start_in_dying", int'(state), 2);
    for (int i = 1; i <= 120; i++) begin
      frame_fall();
      if (i == 119) check("dying_119", int'(state), 2);
      if (i == 120) begin
        check("dying_120_state", int'(state), 3);
        check("dying_120_rr", int'(round_reset), 1);
      end
    end

    enemy_hit = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      frame_fall();
      if (i == 8) check("blink_8", int'(bm_visible), 0);
      if (i == 16) check("blink_16", int'(bm_visible), 1);
      if (i == 89) check("invuln_lives", int'(lives), 2);
      if (i == 90) check("invuln_exit", int'(state), 1);
    end
    @(negedge clk);
    enemy_hit = 1'b0;
    check("held_hit_lives", int'(lives), 1);
    check("held_hit_state", int'(state), 2);

    for (int i = 0; i < 120 + 90; i++) frame_fall();
    @(negedge clk);
    check("back_play", int'(state), 1);
    enemy_hit = 1'b1;
    all_killed = 1'b1;
    @(negedge clk);
    enemy_hit = 1'b0;
    all_killed = 1'b0;
    check("lost_state", int'(state), 4);
    check("lost_lives", int'(lives), 0);
    check("lost_mode", int'(screen_mode), 1);
    pulse(start);
    check("restart_state", int'(state), 0);
    check("restart_lives", int'(lives), 3);
    check("restart_rr", int'(round_reset), 1);

    pulse(start);
    pulse(all_killed);
    check("won_state", int'(state), 5);
    check("won_mode", int'(screen_mode), 2);
    pulse(start);
    pulse(start);
    pulse(bomb_hit);
    check("bomb_state", int'(state), 2);
    for (int i = 0; i < 70; i++) frame_fall();

    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_lives", int'(lives), 3);
    check("async_freeze", int'(freeze), 1);
    check("async_rr", int'(round_reset), 0);
    check("async_mode", int'(screen_mode), 3);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_state", int'(state), 0);
    check("post_rst_rr", int'(round_reset), 0);

    for (int i = 0; i < 5000; i++) begin
      vsync      = 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 39) == 0);
      enemy_hit  = ($urandom_range(0, 59) == 0);
      bomb_hit   = ($urandom_range(0, 79) == 0);
      all_killed = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    enemy_hit = 1'b0;
    bomb_hit = 1'b0;
    all_killed = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
